// File: rtl/parity_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | parity_pkg : shared types and constants for the odd-parity generator |
// |              and receiver.                                           |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package parity_pkg;

  localparam int   DEFAULT_DATA_W = 16;
  localparam logic ODD_PARITY     = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2,
    ST_STOP = 2'd3
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/parity_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | parity_rx_if : serial input and word-level valid/ready output bundle |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
interface parity_rx_if #(
  parameter int DATA_W = 16
) ();
  logic              sdi;
  logic              sdi_vld;
  logic [DATA_W-1:0] rx_data;
  logic              rx_perr;
  logic              rx_valid;
  logic              rx_ready;

  // master is the receiver; slave is the link/sink side around it
  modport master (
    input  sdi, sdi_vld, rx_ready,
    output rx_data, rx_perr, rx_valid
  );

  modport slave (
    output sdi, sdi_vld, rx_ready,
    input  rx_data, rx_perr, rx_valid
  );
endinterface
`default_nettype wire

// File: rtl/parity_sat_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | parity_sat_cnt : saturating event counter with synchronous clear     |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module parity_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             inc,
  input  wire logic             clr,
  output logic      [CNT_W-1:0] value
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // clear takes priority over a coincident increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;

endmodule
`default_nettype wire

// File: rtl/parity_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | parity_rx : start/data/parity/stop frame receiver with odd-parity    |
// |             check, valid/ready word output and error statistics.     |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module parity_rx
  import parity_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  parity_rx_if.master           bus,
  input  wire logic             cnt_clr,
  output logic      [CNT_W-1:0] perr_cnt,
  output logic      [CNT_W-1:0] ferr_cnt,
  output logic      [CNT_W-1:0] ovr_cnt
);

  localparam int BCNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  rx_state_e         state_d, state_q;
  logic [DATA_W-1:0] shift_d, shift_q;
  logic [BCNT_W-1:0] bitcnt_d, bitcnt_q;
  logic              par_d, par_q;
  logic [DATA_W-1:0] rx_data_d, rx_data_q;
  logic              rx_perr_d, rx_perr_q;
  logic              rx_valid_d, rx_valid_q;

  logic              handshake;
  logic              frame_done;
  logic              perr_inc;
  logic              ferr_inc;
  logic              ovr_inc;
  logic              word_perr;

  assign handshake = rx_valid_q && bus.rx_ready;
  assign word_perr = (par_q != ODD_PARITY);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bitcnt_d   = bitcnt_q;
    par_d      = par_q;
    frame_done = 1'b0;
    ferr_inc   = 1'b0;

    if (bus.sdi_vld) begin
      case (state_q)
        ST_IDLE: begin
          if (!bus.sdi) begin
            state_d  = ST_DATA;
            shift_d  = '0;
            bitcnt_d = BCNT_W'(DATA_W - 1);
            par_d    = 1'b0;
          end
        end
        ST_DATA: begin
          shift_d = {shift_q[DATA_W-2:0], bus.sdi};
          par_d   = par_q ^ bus.sdi;
          if (bitcnt_q == '0) begin
            state_d = ST_PAR;
          end else begin
            bitcnt_d = bitcnt_q - 1'b1;
          end
        end
        ST_PAR: begin
          par_d   = par_q ^ bus.sdi;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (bus.sdi) begin
            frame_done = 1'b1;
          end else begin
            ferr_inc = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output holding register: a completed frame may load in the same cycle
  // the previous word is handed off, otherwise it is dropped as an overrun.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_perr_d  = rx_perr_q;
    rx_valid_d = rx_valid_q;
    perr_inc   = 1'b0;
    ovr_inc    = 1'b0;

    if (handshake) begin
      rx_valid_d = 1'b0;
    end

    if (frame_done) begin
      if (!rx_valid_q || handshake) begin
        rx_data_d  = shift_q;
        rx_perr_d  = word_perr;
        rx_valid_d = 1'b1;
        perr_inc   = word_perr;
      end else begin
        ovr_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bitcnt_q   <= '0;
      par_q      <= 1'b0;
      rx_data_q  <= '0;
      rx_perr_q  <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      par_q      <= par_d;
      rx_data_q  <= rx_data_d;
      rx_perr_q  <= rx_perr_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_perr  = rx_perr_q;
  assign bus.rx_valid = rx_valid_q;

  parity_sat_cnt #(.CNT_W(CNT_W)) u_perr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (perr_inc),
    .clr   (cnt_clr),
    .value (perr_cnt)
  );

  parity_sat_cnt #(.CNT_W(CNT_W)) u_ferr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ferr_inc),
    .clr   (cnt_clr),
    .value (ferr_cnt)
  );

  parity_sat_cnt #(.CNT_W(CNT_W)) u_ovr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ovr_inc),
    .clr   (cnt_clr),
    .value (ovr_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_parity_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_parity_rx : randomized scoreboard bench for parity_rx against a   |
// |                bit-list reference model of the frame format.         |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module tb_parity_rx;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] perr_cnt, ferr_cnt, ovr_cnt;

  parity_rx_if #(.DATA_W(DATA_W)) bus ();

  parity_rx #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.master),
    .cnt_clr  (cnt_clr),
    .perr_cnt (perr_cnt),
    .ferr_cnt (ferr_cnt),
    .ovr_cnt  (ovr_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int xfers = 0;
  int rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random

  // Reference model state
  bit                   m_bits[$];
  logic [DATA_W:0]      sb[$];   // {perr, data}, head = word on the port
  bit                   m_full = 1'b0;
  int                   m_perr = 0, m_ferr = 0, m_ovr = 0;
  bit                   m_hs, m_load, m_pinc, m_finc, m_oinc;
  logic [DATA_W-1:0]    m_word;
  int                   m_ones;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    bus.sdi      = 1'b1;
    bus.sdi_vld  = 1'b0;
    bus.rx_ready = 1'b1;
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.rx_ready = 1'b0;
      1:       bus.rx_ready = 1'b1;
      default: bus.rx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Frame model: collect bits from a start bit until a full frame is
  // gathered, then judge it as a whole.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_bits.delete();
      sb.delete();
      m_full = 1'b0;
      m_perr = 0;
      m_ferr = 0;
      m_ovr  = 0;
    end else begin
      m_hs   = m_full && bus.rx_ready;
      m_load = 1'b0;
      m_pinc = 1'b0;
      m_finc = 1'b0;
      m_oinc = 1'b0;
      if (bus.sdi_vld) begin
        if (m_bits.size() != 0 || bus.sdi == 1'b0) m_bits.push_back(bus.sdi);
        if (m_bits.size() == DATA_W + 3) begin
          m_word = '0;
          m_ones = 0;
          for (int i = 1; i <= DATA_W; i++) begin
            m_word = m_word * 2 + DATA_W'(m_bits[i]);
            m_ones += int'(m_bits[i]);
          end
          m_ones += int'(m_bits[DATA_W+1]);
          if (m_bits[DATA_W+2]) begin
            if (!m_full || m_hs) begin
              sb.push_back({(m_ones % 2 == 0), m_word});
              m_load = 1'b1;
              m_pinc = (m_ones % 2 == 0);
            end else begin
              m_oinc = 1'b1;
            end
          end else begin
            m_finc = 1'b1;
          end
          m_bits.delete();
        end
      end
      if (m_load) m_full = 1'b1;
      else if (m_hs) m_full = 1'b0;
      if (cnt_clr) begin
        m_perr = 0;
        m_ferr = 0;
        m_ovr  = 0;
      end else begin
        if (m_pinc && m_perr < CMAX) m_perr++;
        if (m_finc && m_ferr < CMAX) m_ferr++;
        if (m_oinc && m_ovr  < CMAX) m_ovr++;
      end
    end
  end

  // Monitor: compare port state with the model away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
      chk("rst_rx_data",  32'(bus.rx_data),  32'd0);
      chk("rst_rx_perr",  32'(bus.rx_perr),  32'd0);
      chk("rst_perr_cnt", 32'(perr_cnt), 32'd0);
      chk("rst_ferr_cnt", 32'(ferr_cnt), 32'd0);
      chk("rst_ovr_cnt",  32'(ovr_cnt),  32'd0);
    end else begin
      chk("rx_valid", 32'(bus.rx_valid), 32'(m_full));
      chk("perr_cnt", 32'(perr_cnt), 32'(m_perr));
      chk("ferr_cnt", 32'(ferr_cnt), 32'(m_ferr));
      chk("ovr_cnt",  32'(ovr_cnt),  32'(m_ovr));
      if (bus.rx_valid) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
          chk("rx_data", 32'(bus.rx_data), 32'(sb[0][DATA_W-1:0]));
          chk("rx_perr", 32'(bus.rx_perr), 32'(sb[0][DATA_W]));
          if (bus.rx_ready) begin
            void'(sb.pop_front());
            xfers++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit b, input bit gaps, input bit clr);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        bus.sdi_vld = 1'b0;
        bus.sdi     = 1'($urandom_range(0, 1));
        tick();
      end
    end
    bus.sdi_vld = 1'b1;
    bus.sdi     = b;
    cnt_clr     = clr;
    tick();
    bus.sdi_vld = 1'b0;
    cnt_clr     = 1'b0;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input bit par, input bit stop,
                            input bit gaps, input bit clr_on_stop);
    send_bit(1'b0, gaps, 1'b0);
    for (int i = DATA_W - 1; i >= 0; i--) send_bit(d[i], gaps, 1'b0);
    send_bit(par, gaps, 1'b0);
    send_bit(stop, gaps, clr_on_stop);
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int x0;

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Directed frames
    rdy_mode = 1;
    send_frame(16'hA5A5, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("a5a5_valid", 32'(bus.rx_valid), 32'd1);
    chk("a5a5_data",  32'(bus.rx_data),  32'hA5A5);
    chk("a5a5_perr",  32'(bus.rx_perr),  32'd0);
    tick();
    send_frame(16'h0001, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("p1_data", 32'(bus.rx_data), 32'h0001);
    chk("p1_perr", 32'(bus.rx_perr), 32'd1);
    chk("p1_cnt",  32'(perr_cnt),    32'd1);
    tick();
    send_frame(16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ferr_cnt1", 32'(ferr_cnt), 32'd1);
    send_frame(16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("ffff_data", 32'(bus.rx_data), 32'hFFFF);
    chk("ffff_perr", 32'(bus.rx_perr), 32'd0);
    tick();

    // Overrun with sink stalled, then a single release
    rdy_mode = 0;
    repeat (2) tick();
    send_frame(16'h5555, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(16'h00FF, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    chk("ovr_cnt1", 32'(ovr_cnt), 32'd1);
    chk("ovr_held", 32'(bus.rx_data), 32'h5555);
    x0 = xfers;
    rdy_mode = 1;
    repeat (6) tick();
    chk("ovr_one_xfer", 32'(xfers - x0), 32'd1);

    // Gapped frame, then reset in the middle of data bits
    send_frame(16'hC3C3, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (2) tick();
    chk("gap_data", 32'(bus.rx_data), 32'hC3C3);
    send_frame(16'h0F0F, 1'b0, 1'b1, 1'b0, 1'b0);
    rdy_mode = 0;
    tick();
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    rdy_mode = 1;
    tick();
    send_frame(16'hC3C3, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("post_rst_data", 32'(bus.rx_data), 32'hC3C3);
    chk("post_rst_perr", 32'(perr_cnt), 32'd0);
    tick();

    // Randomized traffic
    rdy_mode = 2;
    for (int n = 0; n < 200; n++) begin
      send_frame(16'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) tick();
    end
    rdy_mode = 1;
    repeat (4) tick();

    // Saturation and clear priority
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    for (int n = 0; n < 260; n++) send_frame(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("perr_sat", 32'(perr_cnt), 32'd255);
    send_frame(16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("clr_wins", 32'(perr_cnt), 32'd0);
    chk("clr_word_perr", 32'(bus.rx_perr), 32'd1);

    repeat (5) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
